// File: rtl/priority_irq_encoder.sv
// Registered priority interrupt encoder: sticky pending bits, per-source mask, one grant per valid/ready handshake.
// Optional macro PRIO_ROUND_ROBIN_EN replaces fixed highest-index priority with a rotating search.
module priority_irq_encoder #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         idle
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [N-1:0]   pending_r;
  logic [N-1:0]   pending_s;
  logic [N-1:0]   elig_s;
  logic [N-1:0]   load_clr_s;
  logic [W-1:0]   sel_idx_s;
  logic [W-1:0]   out_idx_r;
  logic           out_valid_r;
  logic           load_s;
  logic           any_elig_s;

  assign elig_s     = pending_r & mask;
  assign any_elig_s = |elig_s;

`ifdef PRIO_ROUND_ROBIN_EN
  logic [W-1:0] last_grant_r;

  // Rotating search: pick the eligible source closest below last_grant, wrapping 0 -> N-1.
  always_comb begin
    int start_v;
    int dist_v;
    int best_v;
    sel_idx_s = '0;
    best_v    = N;
    if (last_grant_r == '0) begin
      start_v = N - 1;
    end else begin
      start_v = int'(last_grant_r) - 1;
    end
    for (int i = 0; i < N; i++) begin
      dist_v = (start_v >= i) ? (start_v - i) : (start_v - i + N);
      if (elig_s[i] && (dist_v < best_v)) begin
        best_v    = dist_v;
        sel_idx_s = W'(i);
      end else begin
        best_v    = best_v;
      end
    end
  end

  // Remember the most recently loaded grant as the rotation origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= '0;
    end else if (load_s) begin
      last_grant_r <= sel_idx_s;
    end
  end
`else
  // Fixed priority: the highest eligible index wins, later iterations override earlier ones.
  always_comb begin
    sel_idx_s = '0;
    for (int i = 0; i < N; i++) begin
      if (elig_s[i]) begin
        sel_idx_s = W'(i);
      end else begin
        sel_idx_s = sel_idx_s;
      end
    end
  end
`endif

  // One-hot clear for the bit being loaded into the output register this cycle.
  always_comb begin
    load_clr_s = '0;
    for (int i = 0; i < N; i++) begin
      load_clr_s[i] = load_s && (sel_idx_s == W'(i));
    end
  end

  // Next-state and load decision; req is OR-ed last so a same-cycle request survives the clear.
  always_comb begin
    state_s   = state_r;
    load_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_elig_s) begin
          load_s  = 1'b1;
          state_s = PRESENT;
        end else begin
          state_s = IDLE;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          if (any_elig_s) begin
            load_s  = 1'b1;
            state_s = PRESENT;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = PRESENT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    pending_s = (pending_r & ~load_clr_s) | req;
  end

  // State, pending and presented-grant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pending_r   <= '0;
      out_idx_r   <= '0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      pending_r   <= pending_s;
      out_valid_r <= (state_s == PRESENT);
      if (load_s) begin
        out_idx_r <= sel_idx_s;
      end
    end
  end

  assign out_idx   = out_idx_r;
  assign out_valid = out_valid_r;
  assign pending   = pending_r;
  assign idle      = (state_r == IDLE) && !any_elig_s;

endmodule

// File: tb/tb_priority_irq_encoder.sv
// Self-checking bench for priority_irq_encoder: per-cycle vector table plus a grant scoreboard.
// Round-robin expectations are selected with PRIO_ROUND_ROBIN_EN.
module tb_priority_irq_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic [2:0] out_idx;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pending;
  logic       idle;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] exp_q[$];

  typedef struct {
    logic [7:0] req;
    logic [7:0] mask;
    logic       rdy;
    logic       valid;
    logic [2:0] idx;
    logic [7:0] pend;
    logic       idle;
  } vec_t;

  vec_t tbl[0:25];

  priority_irq_encoder #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mask      (mask),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every completed handshake must match the next expected grant.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got grant %0d expected no grant", out_idx);
      end else begin
        chk("sb_grant", 32'(out_idx), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      req       = tbl[i].req;
      mask      = tbl[i].mask;
      out_ready = tbl[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d valid", i), 32'(out_valid), 32'(tbl[i].valid));
      chk($sformatf("row%0d idx", i),   32'(out_idx),   32'(tbl[i].idx));
      chk($sformatf("row%0d pend", i),  32'(pending),   32'(tbl[i].pend));
      chk($sformatf("row%0d idle", i),  32'(idle),      32'(tbl[i].idle));
    end
  endtask

  initial begin
    int   e;
    logic done;

    // fixed priority: A4 -> 7,5,2
    tbl[0]  = '{8'hA4, 8'hFF, 1'b1, 1'b0, 3'd0, 8'hA4, 1'b0};
    tbl[1]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 3'd7, 8'h24, 1'b0};
    tbl[2]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 3'd5, 8'h04, 1'b0};
    tbl[3]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 3'd2, 8'h00, 1'b0};
    tbl[4]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 3'd2, 8'h00, 1'b1};
    // backpressure: 0 held, late 7 does not preempt
    tbl[5]  = '{8'h01, 8'hFF, 1'b0, 1'b0, 3'd2, 8'h01, 1'b0};
    tbl[6]  = '{8'h00, 8'hFF, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0};
    tbl[7]  = '{8'h00, 8'hFF, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0};
    tbl[8]  = '{8'h00, 8'hFF, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0};
    tbl[9]  = '{8'h80, 8'hFF, 1'b0, 1'b1, 3'd0, 8'h80, 1'b0};
    tbl[10] = '{8'h00, 8'hFF, 1'b0, 1'b1, 3'd0, 8'h80, 1'b0};
    tbl[11] = '{8'h00, 8'hFF, 1'b1, 1'b1, 3'd7, 8'h00, 1'b0};
    tbl[12] = '{8'h00, 8'hFF, 1'b1, 1'b0, 3'd7, 8'h00, 1'b1};
    // mask holds 5,4 pending until unmasked
    tbl[13] = '{8'h30, 8'h0F, 1'b1, 1'b0, 3'd7, 8'h30, 1'b1};
    tbl[14] = '{8'h00, 8'h0F, 1'b1, 1'b0, 3'd7, 8'h30, 1'b1};
    tbl[15] = '{8'h00, 8'hFF, 1'b1, 1'b1, 3'd5, 8'h10, 1'b0};
    tbl[16] = '{8'h00, 8'hFF, 1'b1, 1'b1, 3'd4, 8'h00, 1'b0};
    tbl[17] = '{8'h00, 8'hFF, 1'b1, 1'b0, 3'd4, 8'h00, 1'b1};
    // set-wins: req[3] held, re-granted every cycle
    tbl[18] = '{8'h08, 8'h08, 1'b1, 1'b0, 3'd4, 8'h08, 1'b0};
    tbl[19] = '{8'h08, 8'h08, 1'b1, 1'b1, 3'd3, 8'h08, 1'b0};
    tbl[20] = '{8'h08, 8'h08, 1'b1, 1'b1, 3'd3, 8'h08, 1'b0};
    tbl[21] = '{8'h08, 8'h08, 1'b1, 1'b1, 3'd3, 8'h08, 1'b0};
    tbl[22] = '{8'h00, 8'h08, 1'b1, 1'b1, 3'd3, 8'h00, 1'b0};
    tbl[23] = '{8'h00, 8'h08, 1'b1, 1'b0, 3'd3, 8'h00, 1'b1};
    // lead-in to mid-grant reset
    tbl[24] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 3'd3, 8'hFF, 1'b0};
    tbl[25] = '{8'h00, 8'hFF, 1'b0, 1'b1, 3'd7, 8'h7F, 1'b0};

    rst_n = 1'b0;
    req = 8'h00;
    mask = 8'hFF;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset valid", 32'(out_valid), 32'd0);
    chk("reset idx",   32'(out_idx),   32'd0);
    chk("reset pend",  32'(pending),   32'd0);
    chk("reset idle",  32'(idle),      32'd1);

    exp_q.push_back(3'd7); exp_q.push_back(3'd5); exp_q.push_back(3'd2);
    run_rows(0, 4);
    exp_q.push_back(3'd0); exp_q.push_back(3'd7);
    run_rows(5, 12);
    exp_q.push_back(3'd5); exp_q.push_back(3'd4);
    run_rows(13, 17);
    repeat (4) exp_q.push_back(3'd3);
    run_rows(18, 23);
    run_rows(24, 25);

    // Mid-grant reset with ready high: grant and pending vanish at once, nothing is handed over.
    out_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst valid", 32'(out_valid), 32'd0);
    chk("midrst pend",  32'(pending),   32'd0);
    chk("midrst idle",  32'(idle),      32'd1);
    chk("midrst idx",   32'(out_idx),   32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("postrst valid", 32'(out_valid), 32'd0);
      chk("postrst pend",  32'(pending),   32'd0);
    end
    chk("sb empty before rr", 32'(exp_q.size()), 32'd0);

    // Sustained all-ones requests, then drain.
    for (int n = 0; n < 18; n++) begin
`ifdef PRIO_ROUND_ROBIN_EN
      e = 7 - (n % 8);
`else
      e = (n < 10) ? 7 : 7 - (n - 10);
`endif
      exp_q.push_back(3'(e));
    end
    mask = 8'hFF;
    out_ready = 1'b1;
    req = 8'hFF;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk);
      #1;
      chk("rr pend held", 32'(pending), 32'hFF);
    end
    req = 8'h00;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk);
      #1;
      if (idle && !out_valid) done = 1'b1;
    end
    chk("rr drain done", 32'(done), 32'd1);
    chk("rr pend final", 32'(pending), 32'd0);
    chk("sb empty end", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/priority_irq_encoder.md
Name: priority_irq_encoder

Overview:
- Parametrised, registered successor to the 8:3 combinational priority encoder.
- Latches N request lines into sticky pending bits and applies a per-bit mask.
- Presents the highest-priority pending index, one at a time, through a valid/ready handshake.
- Sits between peripheral request/interrupt sources and a consumer (controller FSM or CPU interface) that services one source per handshake.

Parameters:
- N, default 8: number of request lines (N >= 1).
- W, default (N>1 ? $clog2(N) : 1): width of the index output, derived from N.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request lines, level-sampled every cycle; bit i = source i.
- mask  input  N  enable per source; 1 = eligible for grant, 0 = held pending but not granted.
- out_idx  output  W  index of the granted source; stable while out_valid=1.
- out_valid  output  1  out_idx holds a granted source awaiting consumption.
- out_ready  input  1  consumer accepts out_idx; handshake completes when out_valid & out_ready.
- pending  output  N  current sticky pending register, for status readback.
- idle  output  1  high when the FSM is in IDLE and (pending & mask) == 0.

Behaviour:
- Reset (async, rst_n=0):
  - pending = 0, out_idx = 0, out_valid = 0, FSM = IDLE, idle = 1.
  - A reset mid-operation drops any presented grant and all pending bits immediately. No handshake completes.
- Pending update each cycle: pending_next = (pending & ~load_clr) | req.
  - load_clr is one-hot for the bit loaded into the output register that cycle.
  - If req[k] is high in the same cycle bit k is loaded, set wins: bit k stays pending and is re-granted later.
- Eligibility: elig = pending & mask. The selection is combinational over the registered pending value.
- Priority: fixed, highest index wins (bit N-1 highest, bit 0 lowest), matching the 8:3 encoder ordering.
- FSM IDLE:
  - out_valid = 0.
  - If elig != 0: load out_idx = top(elig), clear that pending bit, go to PRESENT.
  - Otherwise stay in IDLE.
- FSM PRESENT:
  - out_valid = 1; out_idx is held constant.
  - If out_ready = 0: stay in PRESENT. Newly arriving higher-priority requests do not preempt the presented index.
  - If out_ready = 1 and elig != 0: load the next top(elig) in the same cycle and stay in PRESENT (back-to-back, one grant per cycle).
  - If out_ready = 1 and elig == 0: go to IDLE; out_valid drops the next cycle.
- Latency:
  - req high at edge t → pending bit set after edge t.
  - The grant is loaded at edge t+1, so out_valid is high from the cycle after edge t+1: 2 cycles from req to grant.
- Masking:
  - Masked bits accumulate in pending and are never granted.
  - Unmasking makes them eligible on the next evaluation. Masking does not clear pending.
- A granted bit is removed from pending at load time, not at handshake time, so it can never be presented twice for one request.
- N=1: out_idx is always 0; the block behaves as a one-entry request latch with handshake.
- Index arithmetic is unsigned W-bit. An out_idx >= N never occurs.

Optional Feature:
- Macro: PRIO_ROUND_ROBIN_EN.
- Defined:
  - Adds a W-bit last_grant register, reset to 0.
  - The search starts at (last_grant - 1) mod N, scans downward and wraps from 0 to N-1.
  - last_grant updates on every load.
  - Provides fairness under sustained requests.
- Undefined: fixed highest-index priority as above, and no last_grant register exists.

Test Plan:
- Reset/idle: assert rst_n=0 mid-grant with pending=8'hFF → pending=0, out_valid=0, idle=1 immediately; no spurious grant after release.
- Fixed priority: N=8, mask=8'hFF, req=8'b1010_0100 for 1 cycle, out_ready=1 → grants 7, 5, 2 on consecutive cycles, first valid 2 cycles after req; then idle=1.
- Backpressure: req=8'h01, out_ready=0 for 5 cycles, then req=8'h80 → out_idx stays 0 until ready; the next grant after the handshake is 7.
- Mask: req=8'h30, mask=8'h0F → no grant, pending=8'h30; set mask=8'hFF → grants 5 then 4.
- Set-wins collision: hold req[3]=1 continuously with mask=8'h08 and out_ready=1 → index 3 is re-granted every cycle and pending[3] stays 1.
- PRIO_ROUND_ROBIN_EN: req=8'hFF held, out_ready=1 → grant sequence 7, 6, 5, …, 0, 7 (with the macro undefined, 7 repeats every cycle).
